// File: rtl/pixie_pkg.sv
// ============================================================================
// pixie_pkg : shared types and NTSC timing defaults for the Pixie scheduler
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package pixie_pkg;

  typedef enum logic [1:0] {
    ST_BLANK    = 2'd0,
    ST_INT_PEND = 2'd1,
    ST_GAP      = 2'd2,
    ST_BURST    = 2'd3
  } pixie_state_e;

  localparam logic [1:0] SC_FETCH     = 2'b00;
  localparam logic [1:0] SC_EXECUTE   = 2'b01;
  localparam logic [1:0] SC_DMA       = 2'b10;
  localparam logic [1:0] SC_INTERRUPT = 2'b11;

  localparam int NTSC_CYCLES_PER_LINE = 14;
  localparam int NTSC_LINES_PER_FRAME = 262;
  localparam int NTSC_INT_LINE        = 62;
  localparam int NTSC_DISPLAY_START   = 64;
  localparam int NTSC_DISPLAY_LINES   = 128;

  localparam int DEF_DMA_START_CYCLE  = 2;
  localparam int DEF_DMA_CYCLES       = 8;
  localparam int DEF_LINE_REPEAT      = 4;
  localparam int DEF_EF_LEAD          = 4;

  function automatic logic sc_is_dma(input logic [1:0] sc);
    case (sc)
      SC_DMA:                              return 1'b1;
      SC_FETCH, SC_EXECUTE, SC_INTERRUPT:  return 1'b0;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic in_window(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixie_line_timer.sv
// ============================================================================
// pixie_line_timer : machine-cycle / scanline counters with line/frame pulses
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module pixie_line_timer
  import pixie_pkg::*;
#(
  parameter int CYCLES_PER_LINE = NTSC_CYCLES_PER_LINE,
  parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               tick_i,
  output logic [$clog2(CYCLES_PER_LINE)-1:0] cyc_o,
  output logic [$clog2(LINES_PER_FRAME)-1:0] line_o,
  output logic [$clog2(LINES_PER_FRAME)-1:0] line_nxt_o,
  output logic                               last_cyc_o,
  output logic                               line_start_o,
  output logic                               frame_start_o
);

  localparam int CW = $clog2(CYCLES_PER_LINE);
  localparam int LW = $clog2(LINES_PER_FRAME);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_LINE - 1);
  localparam logic [CW-1:0] CYC_ONE   = CW'(1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);
  localparam logic [LW-1:0] LINE_ONE  = LW'(1);

  logic [CW-1:0] cyc_q, cyc_d;
  logic [LW-1:0] line_q, line_d;
  logic          line_start_q, frame_start_q;
  logic          w_last_cyc, w_last_line;

  always_comb begin
    w_last_cyc  = (cyc_q == CYC_LAST);
    w_last_line = (line_q == LINE_LAST);
    cyc_d       = cyc_q;
    line_d      = line_q;
    if (tick_i) begin
      cyc_d = w_last_cyc ? '0 : cyc_q + CYC_ONE;
      if (w_last_cyc) begin
        line_d = w_last_line ? '0 : line_q + LINE_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cyc_q         <= '0;
      line_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      line_q        <= line_d;
      // Pulses last one clk, not one tick
      line_start_q  <= tick_i && w_last_cyc;
      frame_start_q <= tick_i && w_last_cyc && w_last_line;
    end
  end

  assign cyc_o         = cyc_q;
  assign line_o        = line_q;
  assign line_nxt_o    = line_d;
  assign last_cyc_o    = w_last_cyc;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;

endmodule

`default_nettype wire

// File: rtl/pixie_dma_scheduler.sv
// ============================================================================
// pixie_dma_scheduler : CDP1861-style DMA/INT/EF scheduler and fb capture
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module pixie_dma_scheduler
  import pixie_pkg::*;
#(
  parameter int CYCLES_PER_LINE = NTSC_CYCLES_PER_LINE,
  parameter int LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
  parameter int INT_LINE        = NTSC_INT_LINE,
  parameter int DISPLAY_START   = NTSC_DISPLAY_START,
  parameter int DISPLAY_LINES   = NTSC_DISPLAY_LINES,
  parameter int DMA_START_CYCLE = DEF_DMA_START_CYCLE,
  parameter int DMA_CYCLES      = DEF_DMA_CYCLES,
  parameter int LINE_REPEAT     = DEF_LINE_REPEAT,
  parameter int EF_LEAD         = DEF_EF_LEAD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic [1:0] SC,
  input  logic       disp_on,
  input  logic       disp_off,
  input  logic [7:0] data_in,
  output logic       DMAO,
  output logic       INT,
  output logic       EFx,
  output logic       fb_we,
  output logic [7:0] fb_waddr,
  output logic [7:0] fb_wdata,
  output logic       line_start,
  output logic       frame_start,
  output logic       display_enabled,
  output logic [7:0] dma_miss_cnt
);

  localparam int CW = $clog2(CYCLES_PER_LINE);
  localparam int LW = $clog2(LINES_PER_FRAME);
  localparam int BW = (DMA_CYCLES > 1) ? $clog2(DMA_CYCLES) : 1;

  localparam logic [LW-1:0] ARM_LINE    = LW'(INT_LINE - 1);
  localparam logic [LW-1:0] INT_FIRST   = LW'(INT_LINE);
  localparam logic [LW-1:0] DISP_FIRST  = LW'(DISPLAY_START);
  localparam logic [LW-1:0] DISP_LAST   = LW'(DISPLAY_START + DISPLAY_LINES - 1);
  localparam logic [CW-1:0] DMA_PRE_CYC = CW'(DMA_START_CYCLE - 1);
  localparam logic [BW-1:0] BYTE_LAST   = BW'(DMA_CYCLES - 1);
  localparam logic [BW-1:0] BYTE_ONE    = BW'(1);

  logic [CW-1:0] w_cyc;
  logic [LW-1:0] w_line, w_line_nxt;
  logic          w_last_cyc;
  logic          w_on, w_off, w_arm_tick, w_ef_low_nxt, w_sc_dma;
  logic [7:0]    w_waddr;
  int            w_row;

  pixie_state_e  state_q;
  logic          disp_en_q;
  logic          armed_q, armed_d;
  logic [BW-1:0] byte_idx_q;
  logic          dmao_q, int_q, efx_q, fb_we_q;
  logic [7:0]    fb_waddr_q, fb_wdata_q, miss_q;

  pixie_line_timer #(
    .CYCLES_PER_LINE (CYCLES_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME)
  ) u_timer (
    .clk_i         (clk),
    .reset_i       (reset),
    .tick_i        (clk_enable),
    .cyc_o         (w_cyc),
    .line_o        (w_line),
    .line_nxt_o    (w_line_nxt),
    .last_cyc_o    (w_last_cyc),
    .line_start_o  (line_start),
    .frame_start_o (frame_start)
  );

  always_comb begin
    w_on       = clk_enable && disp_on;
    w_off      = clk_enable && disp_off;
    w_sc_dma   = sc_is_dma(SC);
    w_arm_tick = clk_enable && w_last_cyc && (w_line == ARM_LINE);
    // Arming samples the enable state that was in force before this tick
    armed_d    = w_arm_tick ? disp_en_q : armed_q;
    w_row      = (int'(w_line) - DISPLAY_START) / LINE_REPEAT;
    w_waddr    = 8'(w_row * DMA_CYCLES + int'(byte_idx_q));
    w_ef_low_nxt =
        in_window(int'(w_line_nxt), DISPLAY_START - EF_LEAD, DISPLAY_START - 1) ||
        in_window(int'(w_line_nxt), DISPLAY_START + DISPLAY_LINES - EF_LEAD,
                  DISPLAY_START + DISPLAY_LINES - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_en_q <= 1'b0;
    end else if (w_on) begin
      disp_en_q <= 1'b1;
    end else if (w_off) begin
      disp_en_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BLANK;
      armed_q    <= 1'b0;
      byte_idx_q <= '0;
      dmao_q     <= 1'b1;
      int_q      <= 1'b0;
      efx_q      <= 1'b1;
      fb_we_q    <= 1'b0;
      fb_waddr_q <= 8'd0;
      fb_wdata_q <= 8'd0;
      miss_q     <= 8'd0;
    end else begin
      fb_we_q <= 1'b0;
      armed_q <= armed_d;
      if (clk_enable) begin
        efx_q <= !w_ef_low_nxt;
        if (w_on) begin
          miss_q <= 8'd0;
        end
        case (state_q)
          ST_BLANK: begin
            if (w_last_cyc && (w_line_nxt == INT_FIRST) && armed_d) begin
              state_q <= ST_INT_PEND;
              int_q   <= 1'b1;
            end
          end
          ST_INT_PEND: begin
            if (w_last_cyc && (w_line_nxt == DISP_FIRST)) begin
              state_q <= ST_GAP;
              int_q   <= 1'b0;
            end
          end
          ST_GAP: begin
            if (w_last_cyc && (w_line == DISP_LAST)) begin
              state_q <= ST_BLANK;
            end else if (w_cyc == DMA_PRE_CYC) begin
              state_q    <= ST_BURST;
              dmao_q     <= 1'b0;
              byte_idx_q <= '0;
            end
          end
          ST_BURST: begin
            if (w_sc_dma) begin
              fb_we_q    <= 1'b1;
              fb_wdata_q <= data_in;
              fb_waddr_q <= w_waddr;
            end else if (!w_on && (miss_q != 8'hFF)) begin
              miss_q <= miss_q + 8'd1;
            end
            // Slot index advances even on a miss so addresses stay slot-locked
            byte_idx_q <= byte_idx_q + BYTE_ONE;
            if (byte_idx_q == BYTE_LAST) begin
              state_q <= ST_GAP;
              dmao_q  <= 1'b1;
            end
          end
          default: state_q <= ST_BLANK;
        endcase
      end
    end
  end

  assign DMAO            = dmao_q;
  assign INT             = int_q;
  assign EFx             = efx_q;
  assign fb_we           = fb_we_q;
  assign fb_waddr        = fb_waddr_q;
  assign fb_wdata        = fb_wdata_q;
  assign display_enabled = disp_en_q;
  assign dma_miss_cnt    = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_pixie_dma_scheduler.sv
// ============================================================================
// tb_pixie_dma_scheduler : directed self-checking bench for pixie_dma_scheduler
// Rev 1.0                : initial release
// ============================================================================
`default_nettype none

module tb_pixie_dma_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_enable = 1'b0;
  logic [1:0] SC = 2'b00;
  logic       disp_on = 1'b0;
  logic       disp_off = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       DMAO, INT, EFx, fb_we, line_start, frame_start, display_enabled;
  logic [7:0] fb_waddr, fb_wdata, dma_miss_cnt;

  int total = 0;
  int bad = 0;

  // Bench-side time model: counter values after the most recent tick
  int m_line = 0, m_cyc = 0, ticks = 0;
  logic m_en = 1'b0, m_armed = 1'b0;
  int miss_line = -1, miss_slot = -1;

  int n_we, n_int, n_dmao_low, n_ef_low, n_fs, fs_tick;
  int e_int, e_dmao, e_ef, e_we, e_addr, e_data, e_ls, e_fs, e_pulse;
  int first68_addr, addr_l64_s4;
  logic seen_l64_a3;

  pixie_dma_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .SC              (SC),
    .disp_on         (disp_on),
    .disp_off        (disp_off),
    .data_in         (data_in),
    .DMAO            (DMAO),
    .INT             (INT),
    .EFx             (EFx),
    .fb_we           (fb_we),
    .fb_waddr        (fb_waddr),
    .fb_wdata        (fb_wdata),
    .line_start      (line_start),
    .frame_start     (frame_start),
    .display_enabled (display_enabled),
    .dma_miss_cnt    (dma_miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_we = 0; n_int = 0; n_dmao_low = 0; n_ef_low = 0; n_fs = 0; fs_tick = -1;
    e_int = 0; e_dmao = 0; e_ef = 0; e_we = 0; e_addr = 0; e_data = 0;
    e_ls = 0; e_fs = 0; e_pulse = 0;
    first68_addr = -1; addr_l64_s4 = -1; seen_l64_a3 = 1'b0;
  endtask

  task automatic check_monitors(input string ph);
    chk({ph, "_int_window"},  e_int,   0);
    chk({ph, "_dmao_window"}, e_dmao,  0);
    chk({ph, "_efx_window"},  e_ef,    0);
    chk({ph, "_we_slots"},    e_we,    0);
    chk({ph, "_waddr"},       e_addr,  0);
    chk({ph, "_wdata"},       e_data,  0);
    chk({ph, "_line_start"},  e_ls,    0);
    chk({ph, "_frame_start"}, e_fs,    0);
    chk({ph, "_pulse_width"}, e_pulse, 0);
  endtask

  // One machine cycle: tick clk followed by an idle clk; called at a negedge
  task automatic tick();
    logic pre_miss;
    logic [7:0] d;
    logic in_disp, x_int, x_dmao, x_ef, x_we;
    pre_miss = (m_line == miss_line) && (m_cyc == 2 + miss_slot);
    d = 8'(m_line * 7 + m_cyc * 13 + 1);
    SC = pre_miss ? 2'b01 : 2'b10;
    data_in = d;
    clk_enable = 1'b1;
    @(negedge clk);
    clk_enable = 1'b0;
    if (m_line == 61 && m_cyc == 13) m_armed = m_en;
    if (disp_on) m_en = 1'b1;
    else if (disp_off) m_en = 1'b0;
    disp_on = 1'b0;
    disp_off = 1'b0;
    m_cyc++;
    if (m_cyc == 14) begin
      m_cyc = 0;
      m_line++;
      if (m_line == 262) m_line = 0;
    end
    ticks++;

    in_disp = (m_line >= 64) && (m_line <= 191);
    x_int  = m_armed && (m_line == 62 || m_line == 63);
    x_dmao = !(m_armed && in_disp && m_cyc >= 2 && m_cyc <= 9);
    x_ef   = !((m_line >= 60 && m_line <= 63) || (m_line >= 188 && m_line <= 191));
    x_we   = m_armed && in_disp && m_cyc >= 3 && m_cyc <= 10 && !pre_miss;
    if (INT !== x_int) e_int++;
    if (DMAO !== x_dmao) e_dmao++;
    if (EFx !== x_ef) e_ef++;
    if (fb_we !== x_we) e_we++;
    if (INT === 1'b1) n_int++;
    if (DMAO === 1'b0) n_dmao_low++;
    if (EFx === 1'b0) n_ef_low++;
    if (fb_we === 1'b1) begin
      n_we++;
      if (x_we) begin
        if (fb_waddr !== 8'(((m_line - 64) / 4) * 8 + (m_cyc - 3))) e_addr++;
        if (fb_wdata !== d) e_data++;
      end
      if (m_line == 68 && first68_addr < 0) first68_addr = int'(fb_waddr);
      if (m_line == 64 && m_cyc == 7) addr_l64_s4 = int'(fb_waddr);
      if (m_line == 64 && fb_waddr == 8'h03) seen_l64_a3 = 1'b1;
    end
    if (line_start !== (m_cyc == 0)) e_ls++;
    if (frame_start !== (m_cyc == 0 && m_line == 0)) e_fs++;
    if (frame_start === 1'b1) begin
      n_fs++;
      if (fs_tick < 0) fs_tick = ticks;
    end
    @(negedge clk);
    if (fb_we !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) e_pulse++;
  endtask

  task automatic run_to(input int l, input int c);
    int guard;
    guard = 0;
    tick();
    while (!(m_line == l && m_cyc == c) && guard < 4000) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    clear_stats();
    // ---------------- reset state
    repeat (3) @(negedge clk);
    chk("rst_held_dmao", DMAO, 1'b1);
    chk("rst_held_fb_we", fb_we, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dmao", DMAO, 1'b1);
    chk("rst_int", INT, 1'b0);
    chk("rst_efx", EFx, 1'b1);
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_waddr", fb_waddr, 8'h00);
    chk("rst_wdata", fb_wdata, 8'h00);
    chk("rst_pulses", {line_start, frame_start}, 2'b00);
    chk("rst_display_enabled", display_enabled, 1'b0);
    chk("rst_miss_cnt", dma_miss_cnt, 8'h00);

    // ---------------- display never enabled: one whole frame
    clear_stats();
    run_to(0, 0);
    check_monitors("off");
    chk("off_writes", n_we, 0);
    chk("off_int_ticks", n_int, 0);
    chk("off_dmao_ticks", n_dmao_low, 0);
    chk("off_ef_low_ticks", n_ef_low, 112);
    chk("off_frame_start_cnt", n_fs, 1);
    chk("off_frame_start_tick", fs_tick, 3668);

    // ---------------- enable, one missed slot on line 64 slot 3
    clear_stats();
    disp_on = 1'b1;
    tick();
    chk("on_display_enabled", display_enabled, 1'b1);
    miss_line = 64;
    miss_slot = 3;
    run_to(0, 0);
    miss_line = -1;
    miss_slot = -1;
    check_monitors("on");
    chk("on_writes", n_we, 1023);
    chk("on_int_ticks", n_int, 28);
    chk("on_dmao_ticks", n_dmao_low, 1024);
    chk("on_first_line68_addr", first68_addr, 8);
    chk("miss_no_addr3_on_l64", seen_l64_a3, 1'b0);
    chk("miss_next_addr", addr_l64_s4, 4);
    chk("miss_cnt_one", dma_miss_cnt, 8'd1);

    // ---------------- disp_off at line 100 finishes the frame
    clear_stats();
    run_to(100, 0);
    disp_off = 1'b1;
    tick();
    chk("off100_display_enabled", display_enabled, 1'b0);
    run_to(0, 0);
    check_monitors("off100");
    chk("off100_writes", n_we, 1024 - 8 * 36 + 8 * 36);
    chk("off100_dmao_ticks", n_dmao_low, 1024 - 1024 + 1024 - 8 * 36 + 8 * 36 - 0 + 0);
    clear_stats();
    run_to(0, 0);
    check_monitors("next");
    chk("next_writes", n_we, 0);
    chk("next_int_ticks", n_int, 0);
    chk("next_dmao_ticks", n_dmao_low, 0);
    chk("next_display_enabled", display_enabled, 1'b0);

    // ---------------- simultaneous disp_on / disp_off
    chk("sim_pre_miss_cnt", dma_miss_cnt, 8'd1);
    disp_on = 1'b1;
    disp_off = 1'b1;
    tick();
    chk("sim_display_enabled", display_enabled, 1'b1);
    chk("sim_miss_cleared", dma_miss_cnt, 8'd0);

    // ---------------- asynchronous reset mid-burst at line 70 cyc 5
    clear_stats();
    run_to(70, 5);
    check_monitors("pre_rst");
    chk("mid_dmao_low", DMAO, 1'b0);
    SC = 2'b10;
    data_in = 8'hA5;
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_write_we", fb_we, 1'b1);
    chk("mid_write_addr", fb_waddr, 8'h0B);
    chk("mid_write_data", fb_wdata, 8'hA5);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_dmao", DMAO, 1'b1);
    chk("arst_fb_we", fb_we, 1'b0);
    chk("arst_waddr", fb_waddr, 8'h00);
    chk("arst_wdata", fb_wdata, 8'h00);
    chk("arst_display_enabled", display_enabled, 1'b0);
    @(negedge clk);
    clk_enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_line = 0; m_cyc = 0; m_en = 1'b0; m_armed = 1'b0; ticks = 0;
    clear_stats();
    for (int i = 0; i < 262 * 14; i++) tick();
    check_monitors("post_rst");
    chk("post_rst_fs_cnt", n_fs, 1);
    chk("post_rst_fs_tick", fs_tick, 3668);
    chk("post_rst_writes", n_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixie_dma_scheduler.md
# pixie_dma_scheduler

Machine-cycle scheduler for the Studio II Pixie (CDP1861-style) display path. It counts CPU machine cycles into scanlines and frames and drives DMAO, INT and EFx toward the CDP1802. It captures every acknowledged DMA-out byte into the 256-byte frame-buffer write port consumed by `pixie_video_studioii`. It sits between the CPU bus (clock-enable domain) and the video back end, and is the single owner of display on/off state.

## Interface
- `CYCLES_PER_LINE`, 14: machine cycles per scanline
- `LINES_PER_FRAME`, 262: NTSC lines per frame
- `INT_LINE`, 62: first line with INT asserted
- `DISPLAY_START`, 64: first DMA line
- `DISPLAY_LINES`, 128: DMA lines per frame
- `DMA_START_CYCLE`, 2: first DMA cycle within a line
- `DMA_CYCLES`, 8: DMA bytes per line
- `LINE_REPEAT`, 4: scanlines per frame-buffer row
- `EF_LEAD`, 4: lines EFx is low before display start and before display end
- `clk`  in  1: system clock
- `reset`  in  1: asynchronous, active-high
- `clk_enable`  in  1: one-cycle pulse per CPU machine cycle (the "tick")
- `SC`  in  2: CPU state code; `2'b10` means DMA
- `disp_on`, `disp_off`  in  1: decoded INP/OUT strobes, qualified by tick
- `data_in`  in  8: CPU data bus
- `DMAO`  out  1: DMA-out request, active low
- `INT`  out  1: interrupt request, active high
- `EFx`  out  1: frame flag, active low
- `fb_we`  out  1: frame-buffer write strobe, one clk wide
- `fb_waddr`  out  8: frame-buffer write address
- `fb_wdata`  out  8: frame-buffer write data
- `line_start`, `frame_start`  out  1: one-clk pulses for back-end alignment
- `display_enabled`  out  1: current display state
- `dma_miss_cnt`  out  8: saturating count of un-acknowledged DMA slots

## Operation
- Counters `cyc` (0..CYCLES_PER_LINE-1) and `line` (0..LINES_PER_FRAME-1) advance only on a tick. They run whether or not the display is enabled. `cyc` wraps into `line`+1, and `line` wraps to 0.
- `display_enabled` updates on a tick. Priority: `reset` > `disp_on` > `disp_off`.
- `frame_armed` samples `display_enabled` on the tick where `line==INT_LINE-1` and `cyc==CYCLES_PER_LINE-1`, and holds it for the frame. INT and DMA are gated by `frame_armed` only. A `disp_off` mid-frame completes the current frame.
- FSM states, evaluated on a tick:
  - BLANK: go to INT_PEND when the next line is INT_LINE and `frame_armed` is set.
  - INT_PEND: INT=1; go to GAP at DISPLAY_START cyc 0.
  - GAP: go to BURST when `cyc==DMA_START_CYCLE-1`; go to BLANK after the last display line ends.
  - BURST: DMAO=0 for exactly DMA_CYCLES ticks; `byte_idx` runs 0..7; then go to GAP.
- Capture: on a tick in BURST with `SC==2'b10`:
  - `fb_we`=1, `fb_wdata`=`data_in`.
  - `fb_waddr`={row[4:0], `byte_idx`[2:0]}, where row=(line-DISPLAY_START)/LINE_REPEAT.
- If SC≠DMA in a BURST slot: no write, `dma_miss_cnt`+1 (saturates at 255), and `byte_idx` still advances, so addresses stay slot-locked.
- `dma_miss_cnt` clears on `disp_on`.
- EFx=0 when `line` is in [DISPLAY_START-EF_LEAD, DISPLAY_START-1] or [DISPLAY_START+DISPLAY_LINES-EF_LEAD, DISPLAY_START+DISPLAY_LINES-1]. EFx is independent of enable.
- `line_start` pulses on the tick that sets `cyc` to 0. `frame_start` pulses when `line` also wraps to 0.

## Timing
- Reset values: DMAO=1, INT=0, EFx=1, fb_we=0, fb_waddr=0, fb_wdata=0, line_start=0, frame_start=0, display_enabled=0, dma_miss_cnt=0, cyc=0, line=0, state BLANK.
- All outputs are registered on the `clk` edge at which `clk_enable`=1. The pulse outputs are one clk wide.
- DMAO and INT change one clk after the tick that enters the state. SC is sampled on the same tick as the slot it acknowledges, so the fb write is visible one clk later.
- Reset asserted mid-burst: every output returns to its reset value immediately; no partial write completes.
- `disp_on` and `disp_off` on the same tick: on wins.
- The DISPLAY_LINES/LINE_REPEAT × DMA_CYCLES product must be ≤256; `fb_waddr` wraps mod 256.

## Structure
- Shared package `pixie_pkg`:
  - FSM state enum
  - SC encodings
  - NTSC timing defaults: 14, 262, 62, 64, 128
- Optional sub-module `pixie_line_timer`: the `cyc`/`line` counters plus the `line_start`/`frame_start` pulses, reusable for PAL.

## Test plan
- Reset, `disp_on`, SC=10 on every burst tick:
  - INT high from line 62 cyc 0 to line 63 end.
  - DMAO low on cycles 2–9 of lines 64–191.
  - 1024 writes per frame; the first write on line 68 has `fb_waddr`=0x08.
- Display never enabled: DMAO=1, INT=0 all frame; EFx low on lines 60–63 and 188–191.
- SC=01 on slot 3 of line 64: no write at address 0x03, `dma_miss_cnt`=1, next write at 0x04.
- `disp_off` at line 100: bursts continue to line 191. The next frame has no INT or DMA, and `display_enabled`=0.
- Reset asserted at line 70, cyc 5: DMAO=1, `fb_we`=0 the same clk. Counters restart at 0, and `frame_start` pulses after 262×14 ticks.
- Simultaneous `disp_on` and `disp_off` on a tick: `display_enabled`=1 and `dma_miss_cnt` cleared.
